// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding imem requests,
// buffers returns in a prefetch FIFO and feeds IR / Next_IR. Optional macro: FETCH_BYPASS_EN.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int         PF_DEPTH  = 2,
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] NOP_INSTR = 8'b1010_0000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PCwrite,
  input  logic       PCSel,
  input  logic [7:0] branch_target,
  input  logic       IRload,
  input  logic       IR1_Sel,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] IR,
  output logic [7:0] IR_PC,
  output logic [7:0] Next_IR,
  output logic       fetch_stall
);

  localparam int PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int CNT_W = $clog2(PF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       fpc_q, fpc_d;
  logic [7:0]       addr_q, addr_d;
  logic             req_q, req_d;
  logic [7:0]       ir_q, ir_d;
  logic [7:0]       ir_pc_q, ir_pc_d;
  logic             stall_q, stall_d;
  logic [7:0]       data_mem_q [PF_DEPTH];
  logic [7:0]       data_mem_d [PF_DEPTH];
  logic [7:0]       pc_mem_q   [PF_DEPTH];
  logic [7:0]       pc_mem_d   [PF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic redirect, empty, full, ack_ok, bypass, push, pop;

  always_comb begin
    redirect = PCwrite & ~PCSel;
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    ack_ok   = (state_q == S_WAIT) & imem_ack & ~redirect;
`ifdef FETCH_BYPASS_EN
    bypass   = ack_ok & empty & IRload & ~IR1_Sel;
`else
    bypass   = 1'b0;
`endif
    push     = ack_ok & ~bypass;
    pop      = IRload & ~redirect & ~IR1_Sel & ~empty;
  end

  // Request FSM; a redirect always wins the fetch PC, and an in-flight request
  // it orphans is drained in DISCARD because the memory cannot be cancelled.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (!redirect && (count_q < DEPTH_C)) begin
          state_d = S_WAIT;
          addr_d  = fpc_q;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          if (!redirect) fpc_d = fpc_q + 8'd1;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) fpc_d = branch_target;
    req_d = (state_d == S_WAIT) || (state_d == S_DISCARD);
  end

  always_comb begin
    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    stall_d    = 1'b0;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (IRload) ir_d = NOP_INSTR;
    end else begin
      if (push) begin
        data_mem_d[wr_ptr_q] = imem_data;
        pc_mem_d[wr_ptr_q]   = addr_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (IRload) begin
        if (IR1_Sel) begin
          ir_d = NOP_INSTR;
        end else if (!empty) begin
          ir_d    = data_mem_q[rd_ptr_q];
          ir_pc_d = pc_mem_q[rd_ptr_q];
        end else if (bypass) begin
          ir_d    = imem_data;
          ir_pc_d = addr_q;
        end else begin
          ir_d    = NOP_INSTR;
          stall_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      ir_q     <= NOP_INSTR;
      ir_pc_q  <= 8'h00;
      stall_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      stall_q    <= stall_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_mem_q <= data_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  always_comb begin
    if (!empty)      Next_IR = data_mem_q[rd_ptr_q];
    else if (bypass) Next_IR = imem_data;
    else             Next_IR = NOP_INSTR;
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign IR          = ir_q;
  assign IR_PC       = ir_pc_q;
  assign fetch_stall = stall_q;

  a_no_push_full: assert property (@(posedge clock) disable iff (!reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset) !(pop && empty));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a transaction-level model
// (queue of fetched instructions, one outstanding request). Honours FETCH_BYPASS_EN.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int         DEPTH  = 2;
  localparam logic [7:0] NOP    = 8'b1010_0000;
  localparam logic [7:0] RST_PC = 8'h00;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       PCwrite = 1'b0, PCSel = 1'b1, IRload = 1'b0, IR1_Sel = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic       imem_req, fetch_stall;
  logic [7:0] imem_addr, IR, IR_PC, Next_IR;

  int checks = 0;
  int failures = 0;
  bit chkEn = 1'b0;

  logic [7:0]  mem [256];
  logic [15:0] mq[$];
  logic [7:0]  mFpc, mAddr, mIr, mIrPc;
  logic        mOut, mDead, mStall, mIrPcKnown;

  fetch_stage dut (
    .clock(clock), .reset(reset), .PCwrite(PCwrite), .PCSel(PCSel),
    .branch_target(branch_target), .IRload(IRload), .IR1_Sel(IR1_Sel),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .IR(IR), .IR_PC(IR_PC), .Next_IR(Next_IR),
    .fetch_stall(fetch_stall)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timeout waiting for model condition t=%0t", name, $time);
  endtask

  task automatic modelReset();
    mq.delete();
    mFpc = RST_PC; mAddr = RST_PC; mOut = 1'b0; mDead = 1'b0;
    mIr = NOP; mIrPc = 8'h00; mIrPcKnown = 1'b1; mStall = 1'b0;
  endtask

  // One clock edge of the fetch stage, expressed as instruction-level events.
  task automatic modelStep();
    logic redir, got, start, byp;
    logic [7:0] gd, ga, oldFpc;
    logic [15:0] e;
    redir = PCwrite & ~PCSel;
    got = 1'b0; start = 1'b0; byp = 1'b0; gd = 8'h00; ga = 8'h00;
    oldFpc = mFpc;
    if (mOut) begin
      if (imem_ack) begin
        if (!mDead && !redir) begin got = 1'b1; gd = imem_data; ga = mAddr; end
        mOut = 1'b0; mDead = 1'b0;
      end else if (redir) begin
        mDead = 1'b1;
      end
    end else if (!redir && mq.size() < DEPTH) begin
      start = 1'b1;
    end
    mStall = 1'b0;
    if (redir) begin
      mq.delete();
      mFpc = branch_target;
      if (IRload) begin mIr = NOP; mIrPcKnown = 1'b0; end
    end else begin
      if (got) mFpc = mFpc + 8'd1;
      if (IRload) begin
        if (IR1_Sel) begin
          mIr = NOP; mIrPcKnown = 1'b0;
        end else if (mq.size() > 0) begin
          e = mq.pop_front();
          mIr = e[15:8]; mIrPc = e[7:0]; mIrPcKnown = 1'b1;
        end else if (BYP && got) begin
          mIr = gd; mIrPc = ga; mIrPcKnown = 1'b1; byp = 1'b1;
        end else begin
          mIr = NOP; mIrPcKnown = 1'b0; mStall = 1'b1;
        end
      end
      if (got && !byp) mq.push_back({gd, ga});
    end
    if (start) begin mOut = 1'b1; mDead = 1'b0; mAddr = oldFpc; end
  endtask

  task automatic checkOutput();
    logic [7:0] expNext;
    checkVal("cmp_IR", IR, mIr);
    if (mIrPcKnown) checkVal("cmp_IR_PC", IR_PC, mIrPc);
    checkVal("cmp_fetch_stall", {7'b0, fetch_stall}, {7'b0, mStall});
    checkVal("cmp_imem_req", {7'b0, imem_req}, {7'b0, mOut});
    if (mOut) checkVal("cmp_imem_addr", imem_addr, mAddr);
    expNext = (mq.size() > 0) ? mq[0][15:8] : NOP;
    if (BYP && mq.size() == 0 && mOut && !mDead && imem_ack && !(PCwrite & ~PCSel)
        && IRload && !IR1_Sel)
      expNext = imem_data;
    checkVal("cmp_Next_IR", Next_IR, expNext);
  endtask

  always @(negedge clock) if (reset && chkEn) checkOutput();

  // ackMode: 0 none, 1 ack whenever a request is outstanding, 2 random, 3 forced high.
  task automatic applyStimulus(input logic pcw, input logic pcs, input logic [7:0] bt,
                               input logic irl, input logic sel, input int ackMode);
    #1;
    PCwrite = pcw; PCSel = pcs; branch_target = bt; IRload = irl; IR1_Sel = sel;
    case (ackMode)
      1:       imem_ack = mOut;
      2:       imem_ack = mOut && ($urandom_range(0, 1) == 1);
      3:       imem_ack = 1'b1;
      default: imem_ack = 1'b0;
    endcase
    imem_data = mOut ? mem[mAddr] : 8'($urandom);
    @(posedge clock);
    if (reset) modelStep();
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[3] = 8'h05;
    modelReset();
    repeat (3) @(negedge clock);
    checkVal("lit_rst_IR", IR, NOP);
    checkVal("lit_rst_IR_PC", IR_PC, 8'h00);
    checkVal("lit_rst_req", {7'b0, imem_req}, 8'h00);
    checkVal("lit_rst_stall", {7'b0, fetch_stall}, 8'h00);
    checkVal("lit_rst_Next_IR", Next_IR, NOP);
    #2 reset = 1'b1;
    chkEn = 1'b1;

    // Sequential start-up with an always-acking memory.
    applyStimulus(0, 1, 8'h00, 1, 0, 1);
    checkVal("lit_t1_req", {7'b0, imem_req}, 8'h01);
    checkVal("lit_t1_addr", imem_addr, 8'h00);
    checkVal("lit_t1_IR", IR, NOP);
    checkVal("lit_t1_stall", {7'b0, fetch_stall}, 8'h01);
    applyStimulus(0, 1, 8'h00, 1, 0, 1);
    checkVal("lit_t2_req", {7'b0, imem_req}, 8'h00);
    if (BYP) begin
      checkVal("lit_t2_IR_byp", IR, mem[0]);
      checkVal("lit_t2_stall_byp", {7'b0, fetch_stall}, 8'h00);
      checkVal("lit_t2_Next_byp", Next_IR, NOP);
    end else begin
      checkVal("lit_t2_IR", IR, NOP);
      checkVal("lit_t2_stall", {7'b0, fetch_stall}, 8'h01);
      checkVal("lit_t2_Next", Next_IR, mem[0]);
    end
    applyStimulus(0, 1, 8'h00, 1, 0, 1);
    checkVal("lit_t3_req", {7'b0, imem_req}, 8'h01);
    checkVal("lit_t3_addr", imem_addr, 8'h01);
    if (!BYP) begin
      checkVal("lit_t3_IR", IR, mem[0]);
      checkVal("lit_t3_IR_PC", IR_PC, 8'h00);
    end
    repeat (8) applyStimulus(0, 1, 8'h00, 1, 0, 1);

    // Redirect to 40 while the fetch of 04 is outstanding.
    applyStimulus(1, 0, 8'h00, 1, 0, 0);
    n = 0;
    while (!(mOut && !mDead && mAddr == 8'h04) && n < 40) begin
      applyStimulus(0, 1, 8'h00, 1, 0, 1);
      n++;
    end
    if (n >= 40) reportTimeout("wait_addr04");
    applyStimulus(1, 0, 8'h40, 1, 0, 0);
    checkVal("lit_redir_IR", IR, NOP);
    checkVal("lit_redir_Next", Next_IR, NOP);
    checkVal("lit_redir_req", {7'b0, imem_req}, 8'h01);
    applyStimulus(0, 1, 8'h00, 1, 0, 3);
    checkVal("lit_drop_req", {7'b0, imem_req}, 8'h00);
    checkVal("lit_drop_Next", Next_IR, NOP);
    applyStimulus(0, 1, 8'h00, 1, 0, 0);
    checkVal("lit_tgt_req", {7'b0, imem_req}, 8'h01);
    checkVal("lit_tgt_addr", imem_addr, 8'h40);

    // Stall with IRload low: FIFO fills to DEPTH and fetching stops.
    applyStimulus(1, 0, 8'h10, 0, 0, 0);
    repeat (10) applyStimulus(0, 1, 8'h00, 0, 0, 1);
    checkVal("lit_stop_req", {7'b0, imem_req}, 8'h00);
    checkVal("lit_stop_Next", Next_IR, mem[8'h10]);
    applyStimulus(0, 1, 8'h00, 1, 0, 0);
    checkVal("lit_resume_IR", IR, mem[8'h10]);
    checkVal("lit_resume_IR_PC", IR_PC, 8'h10);
    checkVal("lit_resume_Next", Next_IR, mem[8'h11]);
    applyStimulus(0, 1, 8'h00, 1, 0, 1);
    checkVal("lit_resume2_IR_PC", IR_PC, 8'h11);

    // PC wrap FE -> FF -> 00.
    applyStimulus(1, 0, 8'hFE, 0, 0, 0);
    repeat (8) applyStimulus(0, 1, 8'h00, 0, 0, 1);
    applyStimulus(0, 1, 8'h00, 1, 0, 0);
    checkVal("lit_wrap_IR", IR, mem[8'hFE]);
    checkVal("lit_wrap_IR_PC_FE", IR_PC, 8'hFE);
    applyStimulus(0, 1, 8'h00, 1, 0, 0);
    checkVal("lit_wrap_IR_PC_FF", IR_PC, 8'hFF);
    checkVal("lit_wrap_req", {7'b0, imem_req}, 8'h01);
    checkVal("lit_wrap_addr", imem_addr, 8'h00);
    applyStimulus(0, 1, 8'h00, 1, 0, 1);
    applyStimulus(0, 1, 8'h00, 1, 0, 0);

    // Async reset while a request is outstanding; stray ack afterwards is ignored.
    n = 0;
    while (!(mOut && !mDead) && n < 8) begin
      applyStimulus(0, 1, 8'h00, 0, 0, 0);
      n++;
    end
    if (n >= 8) reportTimeout("wait_for_wait_state");
    #1 reset = 1'b0;
    modelReset();
    #1;
    checkVal("lit_arst_req", {7'b0, imem_req}, 8'h00);
    checkVal("lit_arst_IR", IR, NOP);
    checkVal("lit_arst_Next", Next_IR, NOP);
    @(negedge clock);
    #2 reset = 1'b1;
    applyStimulus(0, 1, 8'h00, 0, 0, 3);
    checkVal("lit_post_rst_req", {7'b0, imem_req}, 8'h01);
    checkVal("lit_post_rst_addr", imem_addr, RST_PC);
    checkVal("lit_post_rst_Next", Next_IR, NOP);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 99) < 20), ($urandom_range(0, 1) == 1), 8'($urandom),
                    ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 10), 2);
    end

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
